// File: rtl/vec_dot.sv
// vec_dot: fixed-point 3-vector dot product with one shared multiplier,
// a wide accumulator and saturating Q realignment between two FIFO interfaces.
module vec_dot #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0][DATA_WIDTH-1:0] x,
  input  logic [2:0][DATA_WIDTH-1:0] y,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  output logic [DATA_WIDTH-1:0]      out,
  input  logic                       out_full,
  output logic                       out_wr_en
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + 2;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WRITE} state_t;
  state_t                       state;
  logic [1:0]                   idx;
  logic [2:0][DATA_WIDTH-1:0]   xr, yr;
  logic signed [PW-1:0]         prod;
  logic signed [AW-1:0]         acc, acc_next, shifted;
  logic [DATA_WIDTH-1:0]        sat;
  logic                         fits;
  always_comb begin
    out_wr_en = reset && state == S_WRITE && !out_full;
    in_rd_en  = reset && !in_empty && (state == S_IDLE || out_wr_en);
    prod      = PW'($signed(xr[idx])) * PW'($signed(yr[idx]));
    acc_next  = acc + AW'(prod);
    shifted   = acc_next >>> FRAC_BITS;
    // value fits when every bit above the result sign bit matches it
    fits      = &shifted[AW-1:DATA_WIDTH-1] || ~|shifted[AW-1:DATA_WIDTH-1];
    sat       = fits ? shifted[DATA_WIDTH-1:0]
                     : {shifted[AW-1], {(DATA_WIDTH-1){~shifted[AW-1]}}};
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      acc   <= '0;
      xr    <= '0;
      yr    <= '0;
      out   <= '0;
    end else if (in_rd_en) begin
      xr    <= x;
      yr    <= y;
      acc   <= '0;
      idx   <= '0;
      state <= S_MUL;
    end else if (state == S_MUL) begin
      acc <= acc_next;
      idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
      if (idx == 2'd2) begin
        out   <= sat;
        state <= S_WRITE;
      end
    end else if (out_wr_en) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_vec_dot.sv
// tb_vec_dot: directed and random checks of vec_dot against an arithmetic dot-product model.
module tb_vec_dot;
  localparam int W = 32;
  typedef logic [2:0][W-1:0] vec_t;
  typedef struct packed {vec_t a; vec_t b;} pair_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  vec_t         x = '0;
  vec_t         y = '0;
  logic         in_empty = 1'b1;
  logic         out_full = 1'b0;
  logic         in_rd_en, out_wr_en;
  logic [W-1:0] out;

  always #5 clock = ~clock;

  vec_dot #(.DATA_WIDTH(W), .FRAC_BITS(16)) dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out(out), .out_full(out_full), .out_wr_en(out_wr_en)
  );

  pair_t        src[$];
  logic [W-1:0] got[$];
  int           rd_cyc[$], wr_cyc[$];
  int           cyc_n = 0, n_cmp = 0, n_err = 0;
  logic         rst_v = 1'b0, full_v = 1'b0, last_rd = 1'b0, last_wr = 1'b0;

  function automatic vec_t mk(logic [W-1:0] v0, logic [W-1:0] v1, logic [W-1:0] v2);
    vec_t v;
    v[0] = v0; v[1] = v1; v[2] = v2;
    return v;
  endfunction

  // exact sum of products, floor division by 2^16, then clamp to int32
  function automatic logic [W-1:0] model(vec_t a, vec_t b);
    logic signed [127:0] s, q;
    s = '0;
    for (int i = 0; i < 3; i++) s = s + 128'($signed(a[i])) * 128'($signed(b[i]));
    q = s >>> 16;
    if (q > 128'sd2147483647) return 32'h7fffffff;
    if (q < -128'sd2147483648) return 32'h80000000;
    return q[31:0];
  endfunction

  function automatic logic [W-1:0] rnd(bit big);
    logic [31:0] t;
    t = $urandom;
    return big ? t : {{12{t[19]}}, t[19:0]};
  endfunction

  function automatic vec_t rvec(bit big);
    return mk(rnd(big), rnd(big), rnd(big));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(vec_t a, vec_t b);
    pair_t p;
    p.a = a; p.b = b;
    src.push_back(p);
  endtask

  // one clock: drive inputs from the upstream queue at negedge, sample handshakes just after
  task automatic cyc();
    @(negedge clock);
    if (last_rd) void'(src.pop_front());
    reset    = rst_v;
    out_full = full_v;
    in_empty = src.size() == 0;
    if (src.size() > 0) begin
      x = src[0].a;
      y = src[0].b;
    end
    #1;
    last_rd = in_rd_en;
    last_wr = out_wr_en;
    if (last_rd) rd_cyc.push_back(cyc_n);
    if (last_wr) begin
      got.push_back(out);
      wr_cyc.push_back(cyc_n);
    end
    cyc_n++;
  endtask

  task automatic wait_got(int n, int budget, string tag);
    for (int i = 0; i < budget && got.size() < n; i++) cyc();
    chk({tag, "_count"}, got.size(), n);
  endtask

  task automatic finish_one(string tag, logic [W-1:0] exp);
    int n;
    n = got.size() + 1;
    wait_got(n, 40, tag);
    if (got.size() >= n) begin
      chk(tag, got[n-1], exp);
      chk({tag, "_lat"}, wr_cyc[n-1] - rd_cyc[$], 4);
    end
    repeat (6) cyc();
    chk({tag, "_once"}, got.size(), n);
  endtask

  task automatic run_one(string tag, vec_t a, vec_t b, logic [W-1:0] exp);
    push(a, b);
    finish_one(tag, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         pa, pb, pc, pd;
    logic [W-1:0] held;
    logic [W-1:0] exps[$];
    int           bw, br, nw;

    // reset holds handshakes low even with data waiting upstream
    push(mk(32'h00010000, 32'h00020000, 32'h00030000), mk(32'h00040000, 32'h00050000, 32'h00060000));
    repeat (3) begin
      cyc();
      chk("rst_rd", last_rd, 0);
      chk("rst_wr", last_wr, 0);
      chk("rst_out", out, 0);
    end
    rst_v = 1'b1;
    finish_one("basic", 32'h00200000);

    run_one("neg_1p5", mk(32'hFFFE8000, 0, 0), mk(32'h00020000, 0, 0), 32'hFFFD0000);
    run_one("floor", mk(32'hFFFFFFFF, 0, 0), mk(32'h00008000, 0, 0), 32'hFFFFFFFF);
    run_one("sat_pos", mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
            mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 32'h7FFFFFFF);
    run_one("sat_neg", mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
            mk(32'h80000000, 32'h80000000, 32'h80000000), 32'h80000000);

    // backpressure: result held while full, next pair waits, then pops with the write
    full_v = 1'b1;
    pa = rvec(0); pb = rvec(0); pc = rvec(0); pd = rvec(0);
    push(pa, pb);
    push(pc, pd);
    for (int i = 0; i < 20 && !last_rd; i++) cyc();
    chk("bp_pop", last_rd, 1);
    repeat (4) cyc();
    held = out;
    chk("bp_val", out, model(pa, pb));
    chk("bp_rd0", last_rd, 0);
    chk("bp_wr0", last_wr, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_rd", last_rd, 0);
      chk("bp_wr", last_wr, 0);
      chk("bp_hold", out, held);
    end
    full_v = 1'b0;
    nw = got.size();
    cyc();
    chk("bp_wr_rel", last_wr, 1);
    chk("bp_rd_rel", last_rd, 1);
    if (got.size() > nw) chk("bp_out", got[nw], model(pa, pb));
    finish_one("bp_next", model(pc, pd));

    // streaming: eight preloaded pairs, mixing saturating and in-range magnitudes
    bw = got.size();
    br = rd_cyc.size();
    for (int k = 0; k < 8; k++) begin
      pa = rvec(k[0]);
      pb = rvec(k[0]);
      push(pa, pb);
      exps.push_back(model(pa, pb));
    end
    wait_got(bw + 8, 80, "stream");
    for (int k = 0; k < 8; k++)
      if (got.size() > bw + k) chk("stream_val", got[bw+k], exps[k]);
    if (got.size() >= bw + 8 && rd_cyc.size() >= br + 8)
      for (int k = 0; k < 7; k++) begin
        chk("stream_gap", wr_cyc[bw+k+1] - wr_cyc[bw+k], 4);
        chk("stream_coin", rd_cyc[br+k+1], wr_cyc[bw+k]);
      end
    repeat (6) cyc();

    // reset during the second multiply cycle drops the pair; the next one is clean
    nw = got.size();
    push(rvec(0), rvec(0));
    for (int i = 0; i < 20 && !last_rd; i++) cyc();
    chk("rmid_pop", last_rd, 1);
    cyc();
    rst_v = 1'b0;
    cyc();
    chk("rmid_rd", last_rd, 0);
    chk("rmid_wr", last_wr, 0);
    rst_v = 1'b1;
    pa = rvec(0); pb = rvec(0);
    push(pa, pb);
    cyc();
    chk("rmid_out", out, 0);
    chk("rmid_idle_rd", last_rd, 1);
    finish_one("after_rst", model(pa, pb));
    chk("rmid_total", got.size(), nw + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
